ram_uart_sequencer: RTL and testbench



---
 rtl/ram_uart_pkg.sv | 23 ++
 rtl/ram_uart_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ram_uart_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_uart_pkg.sv
// ram_uart_pkg
// Shared definitions for the RAM/UART sequencer and main control:
//   - state_t : sequencer FSM states
//   - CMD_RD / CMD_WR : UART command bytes decoded by main control
package ram_uart_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_WAIT  = 4'd1,
        WR_STORE = 4'd2,
        WR_DONE  = 4'd3,
        RD_ADDR  = 4'd4,
        RD_DATA  = 4'd5,
        RD_SEND  = 4'd6,
        RD_HOLD  = 4'd7,
        RD_WAIT  = 4'd8,
        RD_DONE  = 4'd9
    } state_t;

    localparam logic [7:0] CMD_RD = 8'hF0;
    localparam logic [7:0] CMD_WR = 8'h0F;

endpackage

// File: rtl/ram_uart_sequencer.sv
// ram_uart_sequencer
// Owns the external single-port byte RAM between the UART receiver and
// transmitter. A rising start_wr stores the next 2**ADDR_W received bytes at
// addresses 0..N-1; a rising start_rd reads 0..N-1 and sends each byte to the
// transmitter. done_wr / done_rd pulse once when the job ends.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_wr, start_rd  job request levels (rising edge, seen in IDLE)
//   rxrdy, rxdw         received-byte strobe and data
//   txbusy              transmitter busy
//   txstart, txdw       transmit strobe and byte (txdw held while txbusy)
//   ram_we, ram_addr,
//   ram_din, ram_dout   RAM port (ram_dout has 1-cycle read latency)
//   done_wr, done_rd    job-complete pulses
//   busy                high whenever the FSM is not in IDLE
module ram_uart_sequencer
    import ram_uart_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              rxrdy,
    input  logic [DATA_W-1:0] rxdw,
    input  logic              txbusy,
    output logic              txstart,
    output logic [DATA_W-1:0] txdw,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              done_wr,
    output logic              done_rd,
    output logic              busy
);

    state_t state_reg;
    logic   start_wr_q;
    logic   start_rd_q;

    logic start_wr_edge;
    logic start_rd_edge;
    logic addr_last;

    assign start_wr_edge = start_wr & ~start_wr_q;
    assign start_rd_edge = start_rd & ~start_rd_q;
    // ram_addr doubles as the job's byte counter; the last byte is all-ones.
    assign addr_last     = &ram_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            start_wr_q <= 1'b0;
            start_rd_q <= 1'b0;
            txstart    <= 1'b0;
            txdw       <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            done_wr    <= 1'b0;
            done_rd    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_wr_q <= start_wr;
            start_rd_q <= start_rd;

            // Strobes are single-cycle unless a state re-asserts them.
            ram_we  <= 1'b0;
            txstart <= 1'b0;
            done_wr <= 1'b0;
            done_rd <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Write wins when both edges land in the same cycle.
                    if (start_wr_edge) begin
                        state_reg <= WR_WAIT;
                        ram_addr  <= '0;
                        busy      <= 1'b1;
                    end else if (start_rd_edge) begin
                        state_reg <= RD_ADDR;
                        ram_addr  <= '0;
                        busy      <= 1'b1;
                    end
                end

                WR_WAIT: begin
                    if (rxrdy) begin
                        ram_din   <= rxdw;
                        ram_we    <= 1'b1;
                        state_reg <= WR_STORE;
                    end
                end

                WR_STORE: begin
                    if (addr_last) begin
                        done_wr   <= 1'b1;
                        state_reg <= WR_DONE;
                    end else begin
                        ram_addr  <= ram_addr + ADDR_W'(1);
                        state_reg <= WR_WAIT;
                    end
                end

                WR_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                RD_ADDR: begin
                    // ram_addr is already presented; the RAM samples it now.
                    state_reg <= RD_DATA;
                end

                RD_DATA: begin
                    txdw      <= ram_dout;
                    // Fire txstart in the first RD_SEND cycle when the
                    // transmitter is idle. txbusy only rises after a txstart
                    // we issue, so "idle now" still holds next cycle.
                    txstart   <= ~txbusy;
                    state_reg <= RD_SEND;
                end

                RD_SEND: begin
                    if (txstart) begin
                        state_reg <= RD_HOLD;
                    end else if (!txbusy) begin
                        txstart <= 1'b1;
                    end
                end

                RD_HOLD: begin
                    // Gives the transmitter a cycle to raise txbusy.
                    state_reg <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (!txbusy) begin
                        if (addr_last) begin
                            done_rd   <= 1'b1;
                            state_reg <= RD_DONE;
                        end else begin
                            ram_addr  <= ram_addr + ADDR_W'(1);
                            state_reg <= RD_ADDR;
                        end
                    end
                end

                RD_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_uart_sequencer.sv
// Testbench for ram_uart_sequencer with ADDR_W=2 (N=4), a synchronous RAM
// model and a 10-cycle UART transmitter model. Expected RAM writes, tx bytes
// and done pulses are queued by the stimulus; a negedge monitor pops them.
module tb_ram_uart_sequencer;
    import ram_uart_pkg::*;

    localparam int AW = 2;
    localparam int DW = 8;

    localparam int EV_WR  = 0;
    localparam int EV_TX  = 1;
    localparam int EV_DWR = 2;
    localparam int EV_DRD = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_wr, start_rd;
    logic          rxrdy;
    logic [DW-1:0] rxdw;
    logic          txbusy;
    logic          txstart;
    logic [DW-1:0] txdw;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          done_wr, done_rd;
    logic          busy;

    always #5 clk = ~clk;

    ram_uart_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_wr (start_wr),
        .start_rd (start_rd),
        .rxrdy    (rxrdy),
        .rxdw     (rxdw),
        .txbusy   (txbusy),
        .txstart  (txstart),
        .txdw     (txdw),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .done_wr  (done_wr),
        .done_rd  (done_rd),
        .busy     (busy)
    );

    // Single-port synchronous RAM model.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // UART tx model: busy for 10 cycles starting the cycle after txstart.
    int tx_cnt;
    always @(posedge clk) begin
        if (rst) begin
            txbusy <= 1'b0;
            tx_cnt <= 0;
        end else if (txstart) begin
            txbusy <= 1'b1;
            tx_cnt <= 9;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end else begin
            txbusy <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;
    ev_t expq[$];

    task automatic push_ev(input int kind, input int addr, input int data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expq.push_back(e);
    endtask

    task automatic push_write_job(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3);
        push_ev(EV_WR, 0, b0);
        push_ev(EV_WR, 1, b1);
        push_ev(EV_WR, 2, b2);
        push_ev(EV_WR, 3, b3);
        push_ev(EV_DWR, 0, 0);
    endtask

    task automatic push_read_job(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
        push_ev(EV_TX, 0, b0);
        push_ev(EV_TX, 0, b1);
        push_ev(EV_TX, 0, b2);
        push_ev(EV_TX, 0, b3);
        push_ev(EV_DRD, 0, 0);
    endtask

    // Pops the next expected event and compares it against what the DUT did.
    task automatic observe(input int kind, input int addr, input int data);
        ev_t e;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=kind%0d addr=%0h data=%0h required=none (cycle %0d)",
                     kind, addr, data, cyc);
        end else begin
            e = expq.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == kind && kind == EV_WR) begin
                check("ram_addr", addr, e.addr);
                check("ram_din", data, e.data);
            end else if (e.kind == kind && kind == EV_TX) begin
                check("txdw", data, e.data);
            end
        end
    endtask

    int done_wr_cnt = 0;
    int done_rd_cnt = 0;
    int last_we_cyc = -10;
    logic [DW-1:0] tx_last = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                observe(EV_WR, int'(ram_addr), int'(ram_din));
                last_we_cyc = cyc;
            end
            if (txstart) begin
                check("txstart_while_idle", txbusy, 1'b0);
                observe(EV_TX, 0, int'(txdw));
                tx_last = txdw;
            end else if (txbusy) begin
                check("txdw_hold", txdw, tx_last);
            end
            if (done_wr) begin
                check("done_wr_latency", cyc, last_we_cyc + 1);
                observe(EV_DWR, 0, 0);
                done_wr_cnt++;
            end
            if (done_rd) begin
                check("done_rd_after_frame", txbusy, 1'b0);
                observe(EV_DRD, 0, 0);
                done_rd_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rxrdy = 1'b1;
        rxdw  = b;
        tick();
        rxrdy = 1'b0;
        check("ram_we_latency", ram_we, 1'b1);
        tick();
    endtask

    task automatic wait_done_wr();
        int start_cnt = done_wr_cnt;
        int n = 0;
        while (done_wr_cnt == start_cnt && n < 200) begin
            tick();
            n++;
        end
        check("done_wr_seen", done_wr_cnt != start_cnt, 1'b1);
    endtask

    task automatic wait_done_rd();
        int start_cnt = done_rd_cnt;
        int n = 0;
        while (done_rd_cnt == start_cnt && n < 300) begin
            tick();
            n++;
        end
        check("done_rd_seen", done_rd_cnt != start_cnt, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_txstart"}, txstart, 1'b0);
        check({tag, "_ram_we"}, ram_we, 1'b0);
        check({tag, "_done_wr"}, done_wr, 1'b0);
        check({tag, "_done_rd"}, done_rd, 1'b0);
        check({tag, "_ram_addr"}, ram_addr, '0);
        check({tag, "_ram_din"}, ram_din, '0);
        check({tag, "_txdw"}, txdw, '0);
    endtask

    initial begin
        int drd_before;
        rst      = 1'b1;
        start_wr = 1'b0;
        start_rd = 1'b0;
        rxrdy    = 1'b0;
        rxdw     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Write 11,22,33,44 to addresses 0..3.
        push_write_job(8'h11, 8'h22, 8'h33, 8'h44);
        start_wr = 1'b1;
        tick();
        check("wr_busy_s1", busy, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_done_wr();
        check("wr_idle_after_done", busy, 1'b0);
        start_wr = 1'b0;
        tick();

        // Read back; check first-byte latency directly.
        push_read_job(8'h11, 8'h22, 8'h33, 8'h44);
        start_rd = 1'b1;
        tick();
        check("rd_addr_s1", ram_addr, 2'd0);
        check("rd_busy_s1", busy, 1'b1);
        tick();
        tick();
        check("rd_txstart_s3", txstart, 1'b1);
        check("rd_txdw_s3", txdw, 8'h11);
        wait_done_rd();
        check("rd_idle_after_done", busy, 1'b0);
        start_rd = 1'b0;
        tick();

        // Command byte in the cycle before start_wr must not be stored.
        push_write_job(8'h55, 8'h66, 8'h77, 8'h88);
        rxrdy = 1'b1;
        rxdw  = CMD_WR;
        tick();
        rxrdy    = 1'b0;
        start_wr = 1'b1;
        tick();
        check("cmd_no_we", ram_we, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        wait_done_wr();
        start_wr = 1'b0;
        tick();
        push_read_job(8'h55, 8'h66, 8'h77, 8'h88);
        start_rd = 1'b1;
        wait_done_rd();
        start_rd = 1'b0;
        tick();

        // Simultaneous start edges: write runs, read is dropped.
        drd_before = done_rd_cnt;
        push_write_job(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        start_wr = 1'b1;
        start_rd = 1'b1;
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        wait_done_wr();
        repeat (30) tick();
        check("both_no_read_busy", busy, 1'b0);
        check("both_no_done_rd", done_rd_cnt, drd_before);
        start_wr = 1'b0;
        start_rd = 1'b0;
        tick();

        // Reset after two bytes of a write job, then a fresh job from 0.
        push_ev(EV_WR, 0, 8'hB1);
        push_ev(EV_WR, 1, 8'hB2);
        start_wr = 1'b1;
        send_byte(8'hB1);
        send_byte(8'hB2);
        rst      = 1'b1;
        start_wr = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        push_write_job(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        start_wr = 1'b1;
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        wait_done_wr();
        start_wr = 1'b0;
        tick();

        // start_rd held high through done_rd must not retrigger.
        push_read_job(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        start_rd = 1'b1;
        wait_done_rd();
        drd_before = done_rd_cnt;
        for (int i = 0; i < 4; i++) begin
            repeat (5) tick();
            check("held_rd_no_busy", busy, 1'b0);
        end
        check("held_rd_no_done", done_rd_cnt, drd_before);
        start_rd = 1'b0;
        tick();
        push_read_job(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        start_rd = 1'b1;
        wait_done_rd();
        start_rd = 1'b0;

        repeat (5) tick();
        check("scoreboard_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
